// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: captures a multi-hot vector and emits one index per
// accepted handshake in priority order, pulsing done after the last code.
module enc8to3_seq #(
    parameter int PRIORITY_HIGH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       en,
    input  logic       ready,
    output logic [2:0] out,
    output logic       valid,
    output logic       busy,
    output logic       none,
    output logic       done
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state, state_nxt;
    logic [7:0] pending, pending_nxt;
    logic [7:0] remain;
    logic [2:0] out_nxt;
    logic       valid_nxt, busy_nxt, none_nxt, done_nxt;

    // Highest set bit when PRIORITY_HIGH, otherwise lowest set bit.
    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIORITY_HIGH != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // The code currently on out is always a set bit of pending.
    assign remain = pending & ~(8'd1 << out);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        out_nxt     = out;
        valid_nxt   = valid;
        busy_nxt    = busy;
        none_nxt    = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
                if (en) begin
                    if (in != 8'h00) begin
                        pending_nxt = in;
                        out_nxt     = pick(in);
                        valid_nxt   = 1'b1;
                        busy_nxt    = 1'b1;
                        state_nxt   = EMIT;
                    end else begin
                        none_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (ready) begin
                    pending_nxt = remain;
                    if (remain != 8'h00) begin
                        out_nxt = pick(remain);
                    end else begin
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 8'h00;
            out     <= 3'b000;
            valid   <= 1'b0;
            busy    <= 1'b0;
            none    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            out     <= out_nxt;
            valid   <= valid_nxt;
            busy    <= busy_nxt;
            none    <= none_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_enc8to3_seq.sv
// Bench for enc8to3_seq: both priority orders run side by side, each with an
// expected-event queue (codes 0..7, 8 = done, 9 = none) drained by a monitor.
module tb_enc8to3_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in;
    logic       en;
    logic       ready;
    logic [2:0] out_h, out_l;
    logic       valid_h, busy_h, none_h, done_h;
    logic       valid_l, busy_l, none_l, done_l;

    int n_checks = 0;
    int n_fail   = 0;
    int qh[$];
    int ql[$];

    enc8to3_seq #(.PRIORITY_HIGH(1)) dut_h (
        .clk(clk), .rst(rst), .in(in), .en(en), .ready(ready),
        .out(out_h), .valid(valid_h), .busy(busy_h), .none(none_h), .done(done_h)
    );

    enc8to3_seq #(.PRIORITY_HIGH(0)) dut_l (
        .clk(clk), .rst(rst), .in(in), .en(en), .ready(ready),
        .out(out_l), .valid(valid_l), .busy(busy_l), .none(none_l), .done(done_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic pop_chk(input int which, input string nm, input int got);
        int exp;
        exp = -1;
        if (which == 0) begin
            if (qh.size() != 0) exp = qh.pop_front();
        end else begin
            if (ql.size() != 0) exp = ql.pop_front();
        end
        check(nm, got, exp);
    endtask

    // Monitor: a code counts when it is handed over (valid && ready at the next edge).
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_h && ready) pop_chk(0, "sb_hi_code", int'(out_h));
            if (done_h)           pop_chk(0, "sb_hi_done", 8);
            if (none_h)           pop_chk(0, "sb_hi_none", 9);
            if (valid_l && ready) pop_chk(1, "sb_lo_code", int'(out_l));
            if (done_l)           pop_chk(1, "sb_lo_done", 8);
            if (none_l)           pop_chk(1, "sb_lo_none", 9);
            check("excl_none_done", int'(none_h && done_h) + int'(none_l && done_l), 0);
            check("excl_valid_none", int'(valid_h && none_h) + int'(valid_l && none_l), 0);
        end
    end

    task automatic push_cap(input logic [7:0] v);
        if (v == 8'h00) begin
            qh.push_back(9);
            ql.push_back(9);
        end else begin
            for (int i = 7; i >= 0; i--) if (v[i]) qh.push_back(i);
            qh.push_back(8);
            for (int i = 0; i < 8; i++) if (v[i]) ql.push_back(i);
            ql.push_back(8);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] v);
        in = v;
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy_h || busy_l) && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) check("wait_idle_timeout", 1, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        in    = 8'h00;
        en    = 1'b0;
        ready = 1'b1;
        #2;
        check("reset_out",   int'(out_h) + int'(out_l), 0);
        check("reset_flags", int'(valid_h) + int'(busy_h) + int'(none_h) + int'(done_h)
                           + int'(valid_l) + int'(busy_l) + int'(none_l) + int'(done_l), 0);
        tick();
        tick();
        rst = 1'b0;

        // 8'b1010_0100 with ready held: 7,5,2 / 2,5,7 then done
        push_cap(8'hA4);
        capture(8'hA4);
        check("a4_c0_hi", int'(out_h), 7);
        check("a4_c0_lo", int'(out_l), 2);
        check("a4_c0_valid", int'(valid_h && valid_l && busy_h && busy_l), 1);
        tick();
        check("a4_c1_hi", int'(out_h), 5);
        check("a4_c1_lo", int'(out_l), 5);
        tick();
        check("a4_c2_hi", int'(out_h), 2);
        check("a4_c2_lo", int'(out_l), 7);
        tick();
        check("a4_done", int'(done_h && done_l), 1);
        check("a4_idle", int'(valid_h) + int'(valid_l) + int'(busy_h) + int'(busy_l), 0);
        tick();
        check("a4_done_pulse", int'(done_h) + int'(done_l), 0);

        // 8'hFF: eight back-to-back codes, busy throughout
        push_cap(8'hFF);
        capture(8'hFF);
        for (int i = 0; i < 8; i++) begin
            check("ff_hi_code", int'(out_h), 7 - i);
            check("ff_lo_code", int'(out_l), i);
            check("ff_valid_busy", int'(valid_h && busy_h && valid_l && busy_l), 1);
            tick();
        end
        check("ff_done", int'(done_h && done_l), 1);
        check("ff_idle", int'(valid_h) + int'(busy_h), 0);
        tick();

        // all-zero capture: single none pulse
        push_cap(8'h00);
        capture(8'h00);
        check("zero_none", int'(none_h && none_l), 1);
        check("zero_quiet", int'(valid_h) + int'(busy_h) + int'(done_h) + int'(valid_l) + int'(busy_l), 0);
        tick();
        check("zero_none_pulse", int'(none_h) + int'(none_l), 0);

        // 8'h12 with stalled consumer and en/in churn during EMIT
        ready = 1'b0;
        push_cap(8'h12);
        capture(8'h12);
        en = 1'b1;
        in = 8'h80;
        for (int i = 0; i < 3; i++) begin
            check("stall_hi_out", int'(out_h), 4);
            check("stall_lo_out", int'(out_l), 1);
            check("stall_valid", int'(valid_h && valid_l), 1);
            tick();
        end
        en    = 1'b0;
        ready = 1'b1;
        check("stall_hold_hi", int'(out_h), 4);
        wait_idle();

        // capture accepted in the same cycle as done
        push_cap(8'h01);
        capture(8'h01);
        check("b2b_first_out", int'(out_h), 0);
        tick();
        check("b2b_done", int'(done_h && done_l), 1);
        push_cap(8'h03);
        capture(8'h03);
        check("b2b_second_valid", int'(valid_h && valid_l), 1);
        check("b2b_second_hi", int'(out_h), 1);
        check("b2b_second_lo", int'(out_l), 0);
        wait_idle();

        // asynchronous reset in mid-emission discards the rest
        push_cap(8'hF0);
        capture(8'hF0);
        tick();
        check("pre_rst_hi", int'(out_h), 6);
        #2;
        rst = 1'b1;
        #1;
        qh.delete();
        ql.delete();
        check("arst_out", int'(out_h) + int'(out_l), 0);
        check("arst_flags", int'(valid_h) + int'(busy_h) + int'(done_h) + int'(none_h)
                          + int'(valid_l) + int'(busy_l) + int'(done_l), 0);
        en = 1'b1;
        in = 8'hFF;
        tick();
        tick();
        check("rst_hold", int'(valid_h) + int'(busy_h) + int'(out_h) + int'(valid_l), 0);
        en  = 1'b0;
        rst = 1'b0;
        check("rst_release_no_done", int'(done_h) + int'(done_l), 0);
        push_cap(8'h01);
        capture(8'h01);
        check("post_rst_out", int'(out_h), 0);
        check("post_rst_valid", int'(valid_h && valid_l), 1);
        tick();
        check("post_rst_done", int'(done_h && done_l), 1);
        tick();
        tick();

        check("sb_hi_drained", qh.size(), 0);
        check("sb_lo_drained", ql.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
